ysyx_22040759_if_stage: RTL and testbench

Instruction-fetch stage of the ysyx_22040759 five-stage RV64 pipeline, directly upstream of the decode stage. It owns the PC and issues one fetch at a time to instruction memory over a request/response interface. Each returned instruction is presented to decode as a {inst, pc} bus under the valid/allowin handshake. It absorbs decode back-pressure with a one-entry skid buffer and discards in-flight fetches on a branch/jump redirect.

---
 rtl/ysyx_22040759_if_stage_pkg.sv | 28 ++
 rtl/ysyx_22040759_if_stage_if.sv | 26 ++
 rtl/ysyx_22040759_if_stage_skid.sv | 36 +++
 rtl/ysyx_22040759_if_stage.sv | 105 ++++++++++
 tb/tb_ysyx_22040759_if_stage.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040759_if_stage_pkg.sv
// Shared widths, reset vector, FSM encoding and bus types for the
// ysyx_22040759 instruction-fetch stage.
package ysyx_22040759_if_stage_pkg;

   localparam int FS_TO_DS_BUS_W = 96;
   localparam int BR_BUS_W       = 65;
   localparam int INST_W         = 32;
   localparam int PC_W           = 64;

   localparam logic [PC_W-1:0] RESET_PC = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      FS_REQ    = 2'd0,
      FS_WAIT   = 2'd1,
      FS_CANCEL = 2'd2
   } fs_state_e;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [PC_W-1:0]   pc;
   } fs_to_ds_t;

   // Fetch addresses are always word aligned, whatever the branch unit sends.
   function automatic logic [PC_W-1:0] alignPc(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ysyx_22040759_if_stage_if.sv
// Handshake and memory bundle between the fetch stage, decode, the branch
// unit and instruction memory.
interface ysyx_22040759_if_stage_if;
   import ysyx_22040759_if_stage_pkg::*;

   logic                      ds_allowin;
   logic                      fs_to_ds_valid;
   logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus;
   logic [BR_BUS_W-1:0]       br_bus;
   logic                      imem_req;
   logic [PC_W-1:0]           imem_addr;
   logic                      imem_ready;
   logic                      imem_rvalid;
   logic [INST_W-1:0]         imem_rdata;

   modport master (
      input  ds_allowin, br_bus, imem_ready, imem_rvalid, imem_rdata,
      output fs_to_ds_valid, fs_to_ds_bus, imem_req, imem_addr
   );

   modport slave (
      output ds_allowin, br_bus, imem_ready, imem_rvalid, imem_rdata,
      input  fs_to_ds_valid, fs_to_ds_bus, imem_req, imem_addr
   );

endinterface

// File: rtl/ysyx_22040759_if_stage_skid.sv
// One-entry skid buffer holding a fetched {inst, pc} while decode stalls.
module ysyx_22040759_if_skid
   import ysyx_22040759_if_stage_pkg::*;
(
   input  logic      i_clk,
   input  logic      i_rst_n,
   input  logic      i_push,
   input  logic      i_pop,
   input  logic      i_flush,
   input  fs_to_ds_t i_data,
   output logic      o_valid,
   output fs_to_ds_t o_data
);

   logic      r_valid;
   fs_to_ds_t r_data;

   // Flush wins so a redirect never leaves a stale wrong-path entry behind.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_push) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_pop) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/ysyx_22040759_if_stage.sv
// Instruction-fetch stage: owns the PC, keeps one fetch outstanding, and
// hands {inst, pc} to decode through an output register plus a skid entry.
module ysyx_22040759_if_stage (
   input logic                          i_clk,
   input logic                          i_rst_n,
   ysyx_22040759_if_stage_if.master     io_bus
);
   import ysyx_22040759_if_stage_pkg::*;

   fs_state_e       r_state;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_reqPc;
   logic            r_outValid;
   fs_to_ds_t       r_out;

   logic            w_skValid;
   fs_to_ds_t       w_skData;
   fs_to_ds_t       w_respData;
   logic            w_brTaken;
   logic [PC_W-1:0] w_brTarget;
   logic            w_req;
   logic            w_fire;
   logic            w_resp;
   logic            w_consume;
   logic            w_land;
   logic            w_push;
   logic            w_pop;

   assign w_brTaken  = io_bus.br_bus[BR_BUS_W-1];
   assign w_brTarget = alignPc(io_bus.br_bus[PC_W-1:0]);

   // Reset gates the request so memory never sees a fetch while held in reset.
   assign w_req      = i_rst_n && (r_state == FS_REQ) && !w_skValid && !w_brTaken;
   assign w_fire     = w_req && io_bus.imem_ready;
   assign w_resp     = (r_state == FS_WAIT) && io_bus.imem_rvalid && !w_brTaken;
   assign w_consume  = r_outValid && io_bus.ds_allowin;
   assign w_land     = w_resp && (!r_outValid || io_bus.ds_allowin);
   assign w_push     = w_resp && r_outValid && !io_bus.ds_allowin;
   assign w_pop      = w_consume && w_skValid && !w_brTaken;
   assign w_respData = {io_bus.imem_rdata, r_reqPc};

   // A redirect with a fetch still in flight must swallow that late response,
   // unless the response shows up in the redirect cycle itself.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= FS_REQ;
         r_pc    <= RESET_PC;
         r_reqPc <= '0;
      end else if (w_brTaken) begin
         r_pc    <= w_brTarget;
         r_state <= ((r_state != FS_REQ) && !io_bus.imem_rvalid) ? FS_CANCEL : FS_REQ;
      end else begin
         case (r_state)
            FS_REQ: begin
               if (w_fire) begin
                  r_reqPc <= r_pc;
                  r_pc    <= r_pc + 64'd4;
                  r_state <= FS_WAIT;
               end
            end
            FS_WAIT: begin
               if (io_bus.imem_rvalid) r_state <= FS_REQ;
            end
            FS_CANCEL: begin
               if (io_bus.imem_rvalid) r_state <= FS_REQ;
            end
            default: r_state <= FS_REQ;
         endcase
      end
   end

   // The skid entry is older than any new response, but both can never be
   // pending together: no fetch issues while the skid entry is occupied.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_outValid <= 1'b0;
         r_out      <= '0;
      end else if (w_brTaken) begin
         r_outValid <= 1'b0;
      end else if (w_land) begin
         r_outValid <= 1'b1;
         r_out      <= w_respData;
      end else if (w_consume) begin
         r_outValid <= w_skValid;
         if (w_skValid) r_out <= w_skData;
      end
   end

   ysyx_22040759_if_skid u_skid (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_brTaken),
      .i_data  (w_respData),
      .o_valid (w_skValid),
      .o_data  (w_skData)
   );

   assign io_bus.imem_req       = w_req;
   assign io_bus.imem_addr      = r_pc;
   assign io_bus.fs_to_ds_valid = r_outValid;
   assign io_bus.fs_to_ds_bus   = r_out;

endmodule

// File: tb/tb_ysyx_22040759_if_stage.sv
// Scoreboard bench for the fetch stage: a memory model plus a program-order
// stream model predict every fetch address and every {inst, pc} decode sees.
module tb_ysyx_22040759_if_stage;
   import ysyx_22040759_if_stage_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   ysyx_22040759_if_stage_if bus ();

   ysyx_22040759_if_stage dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   always #5 clk = ~clk;

   int          testsRun    = 0;
   int          testsFailed = 0;
   logic [95:0] expQ[$];
   bit          outstanding;
   int          waitCnt;
   logic [63:0] memAddr;
   logic [63:0] nextFetch;
   bit          brLast;

   // Distinct instruction word per word address.
   function automatic logic [31:0] memWord(input logic [63:0] a);
      return (a[33:2] * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      bus.br_bus      = '0;
      bus.ds_allowin  = 1'b0;
      bus.imem_ready  = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      #1;
      checkOutput("reset_valid", 96'(bus.fs_to_ds_valid), 96'(0));
      checkOutput("reset_bus", bus.fs_to_ds_bus, 96'(0));
      checkOutput("reset_req", 96'(bus.imem_req), 96'(0));
      expQ.delete();
      outstanding = 1'b0;
      waitCnt     = 0;
      nextFetch   = RESET_PC;
      brLast      = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock cycle: entered and left at a falling edge.
   task automatic applyStimulus(input bit br, input logic [63:0] target, input bit allow,
                                input bit rdy, input int maxLat);
      bit rv;
      bit acc;
      if (brLast) expQ.delete();
      rv = outstanding && (waitCnt == 0);
      bus.br_bus      = {br, target};
      bus.ds_allowin  = allow;
      bus.imem_ready  = rdy;
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rv ? memWord(memAddr) : $urandom;
      #1;
      checkOutput("imem_req", 96'(bus.imem_req), 96'(!outstanding && (expQ.size() < 2) && !br));
      acc = bus.imem_req && rdy;
      if (acc) begin
         checkOutput("imem_addr", 96'(bus.imem_addr), 96'(nextFetch));
         expQ.push_back({memWord(nextFetch), nextFetch});
         memAddr = bus.imem_addr;
      end
      if (rv) outstanding = 1'b0;
      else if (outstanding) waitCnt--;
      if (acc) begin
         outstanding = 1'b1;
         waitCnt     = $urandom_range(maxLat, 0);
      end
      if (br) nextFetch = {target[63:2], 2'b00};
      else if (acc) nextFetch = nextFetch + 64'd4;
      brLast = br;
      @(negedge clk);
   endtask

   // Monitor: every decode handshake must match the oldest expected entry.
   initial begin
      logic [95:0] expBus;
      forever begin
         @(negedge clk);
         #4;
         if (rst_n && bus.fs_to_ds_valid && bus.ds_allowin) begin
            if (expQ.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL delivery: got %h, expected no instruction", bus.fs_to_ds_bus);
            end else begin
               expBus = expQ.pop_front();
               checkOutput("fs_to_ds_bus", bus.fs_to_ds_bus, expBus);
            end
         end
      end
   end

   initial begin
      int n;
      @(negedge clk);

      // Startup latency with a 1-cycle memory.
      resetDut();
      applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 0);
      checkOutput("first_valid_c2", 96'(bus.fs_to_ds_valid), 96'(0));
      applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 0);
      checkOutput("first_valid_c3", 96'(bus.fs_to_ds_valid), 96'(1));
      applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 0);
      checkOutput("second_valid_c4", 96'(bus.fs_to_ds_valid), 96'(0));
      applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 0);
      checkOutput("second_valid_c5", 96'(bus.fs_to_ds_valid), 96'(1));
      repeat (4) applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 0);

      // Decode stalls for 6 cycles once the first instruction is valid.
      resetDut();
      repeat (2) applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 0);
         checkOutput("stall_valid", 96'(bus.fs_to_ds_valid), 96'(1));
      end
      repeat (10) applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 0);

      // Redirect while a fetch is still waiting for its response.
      n = 0;
      while (!(outstanding && waitCnt > 0) && n < 50) begin
         applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 2);
         n++;
      end
      checkOutput("wait_reached", 96'(n < 50), 96'(1));
      applyStimulus(1'b1, 64'h0000_0000_8000_0100, 1'b1, 1'b1, 2);
      repeat (12) applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 2);

      // Redirect coinciding with a response while decode stalls on a full out register.
      n = 0;
      while (!(outstanding && waitCnt == 0 && expQ.size() == 2) && n < 50) begin
         applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1);
         n++;
      end
      checkOutput("rvalid_full_reached", 96'(n < 50), 96'(1));
      applyStimulus(1'b1, 64'h0000_0000_8000_0400, 1'b0, 1'b1, 1);
      checkOutput("redirect_clear_valid", 96'(bus.fs_to_ds_valid), 96'(0));
      repeat (4) applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 1);

      // Redirect with the skid entry occupied.
      n = 0;
      while (!(!outstanding && expQ.size() == 2) && n < 50) begin
         applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1);
         n++;
      end
      checkOutput("skid_full_reached", 96'(n < 50), 96'(1));
      applyStimulus(1'b1, 64'h0000_0000_8000_0600, 1'b0, 1'b1, 1);
      checkOutput("skid_redirect_valid", 96'(bus.fs_to_ds_valid), 96'(0));
      repeat (6) applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 1);

      // Misaligned target, then a target that wraps past the top of memory.
      applyStimulus(1'b1, 64'h0000_0000_8000_0203, 1'b1, 1'b1, 0);
      repeat (8) applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 0);
      applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b1, 0);
      repeat (12) applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 0);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         logic [63:0] tgt;
         tgt = ($urandom_range(1, 0) == 1) ? {$urandom, $urandom}
                                           : (RESET_PC + 64'($urandom_range(1023, 0)));
         applyStimulus($urandom_range(15, 0) == 0, tgt, $urandom_range(3, 0) != 0,
                       $urandom_range(1, 0) == 1, 3);
      end

      // Reset in the middle of a fetch.
      n = 0;
      while (!outstanding && n < 50) begin
         applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 3);
         n++;
      end
      checkOutput("mid_wait_reached", 96'(n < 50), 96'(1));
      resetDut();
      repeat (10) applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 1);

      // Everything accepted must eventually reach decode.
      n = 0;
      while ((expQ.size() != 0 || outstanding) && n < 100) begin
         applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 1);
         n++;
      end
      checkOutput("drain_empty", 96'(expQ.size()), 96'(0));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
